voice_reg_bank: RTL and testbench

- Byte-wide register front end that drives the control inputs of NUM_VOICES synth voices: tone_freq, waveform_enable, pulse_width, ringmod/sync enables, gate and ADSR.
- A host writer (CPU, UART bridge or MIDI decoder) writes registers in a SID-style map into shadow copies.
- Shadow values commit to the voice-facing outputs atomically on a sample tick, so a voice never sees a half-updated 16-bit frequency or pulse width.
- A short gate-off/gate-on pair written within one sample period is stretched so the envelope still retriggers.

---
 rtl/voice_reg_bank_pkg.sv | 34 +++
 rtl/voice_reg_slot.sv | 196 +++++++++++++++++++
 rtl/voice_reg_bank.sv | 93 +++++++++
 tb/tb_voice_reg_bank.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_reg_bank_pkg.sv
// voice_reg_bank_pkg
//   Shared definitions for the voice register bank: the per-voice register
//   map, CTRL bit positions and address field widths. Every voice occupies
//   an 8-byte stride; the address is {voice[7:3], reg[2:0]}.
package voice_reg_bank_pkg;

  // Low address bits select the register inside a voice (stride of 8).
  localparam int REG_OFS_W   = 3;
  localparam int VOICE_IDX_W = 8 - REG_OFS_W;

  // The map splits tone_freq into two bytes, so it is fixed at 16 bits.
  localparam int MAP_FREQ_BITS = 16;

  typedef enum logic [REG_OFS_W-1:0] {
    REG_FREQ_LO = 3'd0,
    REG_FREQ_HI = 3'd1,
    REG_PW_LO   = 3'd2,
    REG_PW_HI   = 3'd3,
    REG_CTRL    = 3'd4,
    REG_AD      = 3'd5,
    REG_SR      = 3'd6,
    REG_RSVD    = 3'd7
  } reg_e;

  // CTRL byte layout; bit 3 is reserved but stored and read back.
  localparam int CTRL_GATE    = 0;
  localparam int CTRL_SYNC    = 1;
  localparam int CTRL_RINGMOD = 2;
  localparam int CTRL_TRI     = 4;
  localparam int CTRL_SAW     = 5;
  localparam int CTRL_PULSE   = 6;
  localparam int CTRL_NOISE   = 7;

endpackage

// File: rtl/voice_reg_slot.sv
// voice_reg_slot
//   One voice's register slot: shadow registers written by the host,
//   active registers seen by the voice, and the commit logic that copies
//   shadow to active on sample_tick.
//
//   Ports
//     main_clk, rst      clock, synchronous active-high reset
//     sample_tick        commit strobe, one cycle per sample period
//     wr_en              accepted write addressed to this voice
//     wr_reg, wr_data    register offset and byte of that write
//     rd_reg, rd_val     combinational shadow readback for the top's read mux
//     tone_freq .. rel   active (committed) voice controls
module voice_reg_slot
  import voice_reg_bank_pkg::*;
#(
  parameter int PULSEWIDTH_BITS = 12
) (
  input  logic                       main_clk,
  input  logic                       rst,
  input  logic                       sample_tick,
  input  logic                       wr_en,
  input  logic [REG_OFS_W-1:0]       wr_reg,
  input  logic [7:0]                 wr_data,
  input  logic [REG_OFS_W-1:0]       rd_reg,
  output logic [7:0]                 rd_val,
  output logic [MAP_FREQ_BITS-1:0]   tone_freq,
  output logic [PULSEWIDTH_BITS-1:0] pulse_width,
  output logic [3:0]                 waveform_enable,
  output logic                       en_ringmod,
  output logic                       en_sync,
  output logic                       gate,
  output logic [3:0]                 attack,
  output logic [3:0]                 decay,
  output logic [3:0]                 sustain,
  output logic [3:0]                 rel
);

  // Bits of PW_HI that are actually stored; the rest are dropped.
  localparam int PW_HI_BITS = PULSEWIDTH_BITS - 8;

  // Shadow (host-visible) registers.
  logic [MAP_FREQ_BITS-1:0]   sh_freq_q, sh_freq_d;
  logic [PULSEWIDTH_BITS-1:0] sh_pw_q, sh_pw_d;
  logic [7:0]                 sh_ctrl_q, sh_ctrl_d;
  logic [7:0]                 sh_ad_q, sh_ad_d;
  logic [7:0]                 sh_sr_q, sh_sr_d;

  // Active (voice-facing) registers.
  logic [MAP_FREQ_BITS-1:0]   act_freq_q, act_freq_d;
  logic [PULSEWIDTH_BITS-1:0] act_pw_q, act_pw_d;
  logic [3:0]                 act_wave_q, act_wave_d;
  logic                       act_ring_q, act_ring_d;
  logic                       act_sync_q, act_sync_d;
  logic                       act_gate_q, act_gate_d;
  logic [7:0]                 act_ad_q, act_ad_d;
  logic [7:0]                 act_sr_q, act_sr_d;

  // dirty: shadow differs from what the voice last saw.
  // gate_cleared: a gate-off was written since the last commit.
  logic dirty_q, dirty_d;
  logic gate_cleared_q, gate_cleared_d;

  logic retrigger;

  always_comb begin
    // NOTE: every next-state value defaults to its current value before any
    // branch, so no path through this block can infer a latch.
    sh_freq_d      = sh_freq_q;
    sh_pw_d        = sh_pw_q;
    sh_ctrl_d      = sh_ctrl_q;
    sh_ad_d        = sh_ad_q;
    sh_sr_d        = sh_sr_q;
    act_freq_d     = act_freq_q;
    act_pw_d       = act_pw_q;
    act_wave_d     = act_wave_q;
    act_ring_d     = act_ring_q;
    act_sync_d     = act_sync_q;
    act_gate_d     = act_gate_q;
    act_ad_d       = act_ad_q;
    act_sr_d       = act_sr_q;
    dirty_d        = dirty_q;
    gate_cleared_d = gate_cleared_q;

    // A gate-off/gate-on pair that both landed in one sample period would
    // otherwise be invisible; force one period of gate low first.
    retrigger = gate_cleared_q && sh_ctrl_q[CTRL_GATE] && act_gate_q;

    if (sample_tick && dirty_q) begin
      act_freq_d     = sh_freq_q;
      act_pw_d       = sh_pw_q;
      act_wave_d     = {sh_ctrl_q[CTRL_NOISE], sh_ctrl_q[CTRL_PULSE],
                        sh_ctrl_q[CTRL_SAW], sh_ctrl_q[CTRL_TRI]};
      act_ring_d     = sh_ctrl_q[CTRL_RINGMOD];
      act_sync_d     = sh_ctrl_q[CTRL_SYNC];
      act_ad_d       = sh_ad_q;
      act_sr_d       = sh_sr_q;
      gate_cleared_d = 1'b0;
      if (retrigger) begin
        act_gate_d = 1'b0;  // dirty stays set so the next tick raises gate
      end else begin
        act_gate_d = sh_ctrl_q[CTRL_GATE];
        dirty_d    = 1'b0;
      end
    end

    // The top never accepts a write in a commit cycle, so the two branches
    // above and below are mutually exclusive in practice.
    if (wr_en && (reg_e'(wr_reg) != REG_RSVD)) begin
      dirty_d = 1'b1;
      case (reg_e'(wr_reg))
        REG_FREQ_LO: sh_freq_d[7:0]  = wr_data;
        REG_FREQ_HI: sh_freq_d[15:8] = wr_data;
        REG_PW_LO:   sh_pw_d[7:0]    = wr_data;
        REG_PW_HI:   sh_pw_d[PULSEWIDTH_BITS-1:8] = wr_data[PW_HI_BITS-1:0];
        REG_CTRL: begin
          sh_ctrl_d = wr_data;
          if (!wr_data[CTRL_GATE]) gate_cleared_d = 1'b1;
        end
        REG_AD:      sh_ad_d = wr_data;
        REG_SR:      sh_sr_d = wr_data;
        default:     ;
      endcase
    end
  end

  // NOTE: every register, shadow copies included, is reset so a reset in
  // the middle of a sample period leaves nothing pending to commit.
  always_ff @(posedge main_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    if (rst) begin
      sh_freq_q      <= '0;
      sh_pw_q        <= '0;
      sh_ctrl_q      <= '0;
      sh_ad_q        <= '0;
      sh_sr_q        <= '0;
      act_freq_q     <= '0;
      act_pw_q       <= '0;
      act_wave_q     <= '0;
      act_ring_q     <= 1'b0;
      act_sync_q     <= 1'b0;
      act_gate_q     <= 1'b0;
      act_ad_q       <= '0;
      act_sr_q       <= '0;
      dirty_q        <= 1'b0;
      gate_cleared_q <= 1'b0;
    end else begin
      sh_freq_q      <= sh_freq_d;
      sh_pw_q        <= sh_pw_d;
      sh_ctrl_q      <= sh_ctrl_d;
      sh_ad_q        <= sh_ad_d;
      sh_sr_q        <= sh_sr_d;
      act_freq_q     <= act_freq_d;
      act_pw_q       <= act_pw_d;
      act_wave_q     <= act_wave_d;
      act_ring_q     <= act_ring_d;
      act_sync_q     <= act_sync_d;
      act_gate_q     <= act_gate_d;
      act_ad_q       <= act_ad_d;
      act_sr_q       <= act_sr_d;
      dirty_q        <= dirty_d;
      gate_cleared_q <= gate_cleared_d;
    end
  end

  // Shadow readback; PW_HI is zero-extended from its stored bits.
  logic [7:0] pw_hi_rd;

  always_comb begin
    pw_hi_rd = '0;
    pw_hi_rd[PW_HI_BITS-1:0] = sh_pw_q[PULSEWIDTH_BITS-1:8];
    rd_val = '0;
    case (reg_e'(rd_reg))
      REG_FREQ_LO: rd_val = sh_freq_q[7:0];
      REG_FREQ_HI: rd_val = sh_freq_q[15:8];
      REG_PW_LO:   rd_val = sh_pw_q[7:0];
      REG_PW_HI:   rd_val = pw_hi_rd;
      REG_CTRL:    rd_val = sh_ctrl_q;
      REG_AD:      rd_val = sh_ad_q;
      REG_SR:      rd_val = sh_sr_q;
      default:     rd_val = '0;
    endcase
  end

  assign tone_freq       = act_freq_q;
  assign pulse_width     = act_pw_q;
  assign waveform_enable = act_wave_q;
  assign en_ringmod      = act_ring_q;
  assign en_sync         = act_sync_q;
  assign gate            = act_gate_q;
  assign attack          = act_ad_q[7:4];
  assign decay           = act_ad_q[3:0];
  assign sustain         = act_sr_q[7:4];
  assign rel             = act_sr_q[3:0];

endmodule

// File: rtl/voice_reg_bank.sv
// voice_reg_bank
//   Byte-wide SID-style register front end for NUM_VOICES synth voices.
//   Host writes land in per-voice shadow registers and are committed to the
//   voice-facing outputs atomically on sample_tick.
//
//   Ports
//     main_clk, rst        clock, synchronous active-high reset
//     sample_tick          commit strobe; writes stall during it
//     wr_valid/wr_ready    write handshake; wr_addr = {voice, reg}, wr_data
//     rd_addr, rd_data     registered shadow readback (one cycle latency)
//     tone_freq .. rel     packed per-voice controls, voice 0 in the LSBs
module voice_reg_bank
  import voice_reg_bank_pkg::*;
#(
  parameter int NUM_VOICES      = 3,
  parameter int FREQ_BITS       = 16,
  parameter int PULSEWIDTH_BITS = 12
) (
  input  logic                                  main_clk,
  input  logic                                  rst,
  input  logic                                  sample_tick,
  input  logic                                  wr_valid,
  output logic                                  wr_ready,
  input  logic [7:0]                            wr_addr,
  input  logic [7:0]                            wr_data,
  input  logic [7:0]                            rd_addr,
  output logic [7:0]                            rd_data,
  output logic [NUM_VOICES*FREQ_BITS-1:0]       tone_freq,
  output logic [NUM_VOICES*PULSEWIDTH_BITS-1:0] pulse_width,
  output logic [NUM_VOICES*4-1:0]               waveform_enable,
  output logic [NUM_VOICES-1:0]                 en_ringmod,
  output logic [NUM_VOICES-1:0]                 en_sync,
  output logic [NUM_VOICES-1:0]                 gate,
  output logic [NUM_VOICES*4-1:0]               attack,
  output logic [NUM_VOICES*4-1:0]               decay,
  output logic [NUM_VOICES*4-1:0]               sustain,
  output logic [NUM_VOICES*4-1:0]               rel
);

  logic       wr_fire;
  logic [7:0] slot_rd [NUM_VOICES];
  logic [7:0] rd_data_d, rd_data_q;

  // Writes are refused in the commit cycle so shadow never changes under a
  // commit; a write to a voice past NUM_VOICES is accepted and dropped.
  assign wr_ready = !rst && !sample_tick;
  assign wr_fire  = wr_valid && wr_ready;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    logic slot_wr;
    assign slot_wr = wr_fire && (wr_addr[7:REG_OFS_W] == VOICE_IDX_W'(v));

    voice_reg_slot #(
      .PULSEWIDTH_BITS (PULSEWIDTH_BITS)
    ) u_slot (
      .main_clk        (main_clk),
      .rst             (rst),
      .sample_tick     (sample_tick),
      .wr_en           (slot_wr),
      .wr_reg          (wr_addr[REG_OFS_W-1:0]),
      .wr_data         (wr_data),
      .rd_reg          (rd_addr[REG_OFS_W-1:0]),
      .rd_val          (slot_rd[v]),
      .tone_freq       (tone_freq[v*FREQ_BITS +: FREQ_BITS]),
      .pulse_width     (pulse_width[v*PULSEWIDTH_BITS +: PULSEWIDTH_BITS]),
      .waveform_enable (waveform_enable[v*4 +: 4]),
      .en_ringmod      (en_ringmod[v]),
      .en_sync         (en_sync[v]),
      .gate            (gate[v]),
      .attack          (attack[v*4 +: 4]),
      .decay           (decay[v*4 +: 4]),
      .sustain         (sustain[v*4 +: 4]),
      .rel             (rel[v*4 +: 4])
    );
  end

  // Out-of-range voices fall through to the zero default.
  always_comb begin
    rd_data_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (rd_addr[7:REG_OFS_W] == VOICE_IDX_W'(v)) rd_data_d = slot_rd[v];
    end
  end

  // Sampled from pre-edge shadow, so a same-cycle write returns the old byte.
  always_ff @(posedge main_clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_voice_reg_bank.sv
// tb_voice_reg_bank
//   Self-checking bench: directed scenarios followed by randomized traffic,
//   every cycle compared against a byte-array reference model of the
//   register map and its commit rules.
module tb_voice_reg_bank;

  localparam int NV = 3;
  localparam int PW = 12;
  localparam logic [7:0] PW_HI_MASK = 8'((1 << (PW - 8)) - 1);

  logic             main_clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample_tick = 1'b0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [7:0]       wr_addr = '0;
  logic [7:0]       wr_data = '0;
  logic [7:0]       rd_addr = '0;
  logic [7:0]       rd_data;
  logic [NV*16-1:0] tone_freq;
  logic [NV*PW-1:0] pulse_width;
  logic [NV*4-1:0]  waveform_enable;
  logic [NV-1:0]    en_ringmod, en_sync, gate;
  logic [NV*4-1:0]  attack, decay, sustain, rel;

  voice_reg_bank #(
    .NUM_VOICES      (NV),
    .FREQ_BITS       (16),
    .PULSEWIDTH_BITS (PW)
  ) dut (
    .main_clk        (main_clk),
    .rst             (rst),
    .sample_tick     (sample_tick),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .tone_freq       (tone_freq),
    .pulse_width     (pulse_width),
    .waveform_enable (waveform_enable),
    .en_ringmod      (en_ringmod),
    .en_sync         (en_sync),
    .gate            (gate),
    .attack          (attack),
    .decay           (decay),
    .sustain         (sustain),
    .rel             (rel)
  );

  always #5 main_clk = ~main_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: register bytes as the host sees them, the bytes the
  // voice last received, and the two per-voice bookkeeping flags.
  logic [7:0] sh  [NV][8];
  logic [7:0] act [NV][8];
  bit         dirty [NV];
  bit         gclr  [NV];
  logic [7:0] rd_exp = '0;
  bit         last_accept;

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      for (int r = 0; r < 8; r++) begin
        sh[v][r]  = '0;
        act[v][r] = '0;
      end
      dirty[v] = 0;
      gclr[v]  = 0;
    end
    rd_exp = '0;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] addr);
    int v = int'(addr[7:3]);
    int r = int'(addr[2:0]);
    if (v >= NV || r == 7) return 8'h00;
    return sh[v][r];
  endfunction

  task automatic model_write(input logic [7:0] addr, input logic [7:0] data);
    int v = int'(addr[7:3]);
    int r = int'(addr[2:0]);
    if (v < NV && r != 7) begin
      sh[v][r] = (r == 3) ? (data & PW_HI_MASK) : data;
      dirty[v] = 1;
      if (r == 4 && data[0] == 1'b0) gclr[v] = 1;
    end
  endtask

  task automatic model_commit();
    bit retrig;
    for (int v = 0; v < NV; v++) begin
      if (dirty[v]) begin
        retrig = gclr[v] && sh[v][4][0] && act[v][4][0];
        for (int r = 0; r < 7; r++) act[v][r] = sh[v][r];
        gclr[v] = 0;
        if (retrig) act[v][4][0] = 1'b0;
        else        dirty[v] = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [NV*16-1:0] e_freq;
    logic [NV*PW-1:0] e_pw;
    logic [NV*4-1:0]  e_wave, e_a, e_d, e_s, e_r;
    logic [NV-1:0]    e_ring, e_sync, e_gate;
    logic [7:0]       c;
    for (int v = 0; v < NV; v++) begin
      c = act[v][4];
      e_freq[v*16 +: 16] = {act[v][1], act[v][0]};
      e_pw[v*PW +: PW]   = PW'({act[v][3], act[v][2]});
      e_wave[v*4 +: 4]   = c[7:4];
      e_ring[v]          = c[2];
      e_sync[v]          = c[1];
      e_gate[v]          = c[0];
      e_a[v*4 +: 4]      = act[v][5] >> 4;
      e_d[v*4 +: 4]      = act[v][5] & 8'h0F;
      e_s[v*4 +: 4]      = act[v][6] >> 4;
      e_r[v*4 +: 4]      = act[v][6] & 8'h0F;
    end
    check("tone_freq",  tone_freq,       e_freq);
    check("pulse_width", pulse_width,    e_pw);
    check("waveform",   waveform_enable, e_wave);
    check("ringmod",    en_ringmod,      e_ring);
    check("sync",       en_sync,         e_sync);
    check("gate",       gate,            e_gate);
    check("attack",     attack,          e_a);
    check("decay",      decay,           e_d);
    check("sustain",    sustain,         e_s);
    check("release",    rel,             e_r);
    check("rd_data",    rd_data,         rd_exp);
  endtask

  // One clock: check ready, advance the model on the current drives, then
  // compare everything just after the edge.
  task automatic cycle();
    bit         acc;
    logic [7:0] rd_e;
    #1;
    check("wr_ready", wr_ready, !rst && !sample_tick);
    acc = wr_valid && !rst && !sample_tick;
    if (rst) begin
      model_reset();
    end else begin
      rd_e = model_read(rd_addr);
      if (sample_tick) model_commit();
      if (acc) model_write(wr_addr, wr_data);
      rd_exp = rd_e;
    end
    @(posedge main_clk);
    #1;
    last_accept = acc;
    compare_all();
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
    bit done = 0;
    wr_valid = 1'b1;
    wr_addr  = addr;
    wr_data  = data;
    for (int i = 0; i < 8 && !done; i++) begin
      cycle();
      done = last_accept;
    end
    check("wr_handshake", done, 1'b1);
    wr_valid = 1'b0;
  endtask

  task automatic do_tick();
    sample_tick = 1'b1;
    cycle();
    sample_tick = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset: outputs zero and wr_ready low while rst is high.
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Frequency bytes commit together on the tick.
    do_write(8'h00, 8'h34);
    do_write(8'h01, 8'h12);
    cycle();
    check("tp1_pre_tick", tone_freq[15:0], 16'h0000);
    do_tick();
    check("tp1_post_tick", tone_freq[15:0], 16'h1234);

    // Write held across a commit cycle stalls one cycle.
    wr_valid = 1'b1; wr_addr = 8'h0D; wr_data = 8'hA5;
    sample_tick = 1'b1;
    cycle();
    check("tp2_stall_accept", last_accept, 1'b0);
    sample_tick = 1'b0;
    cycle();
    check("tp2_accept", last_accept, 1'b1);
    wr_valid = 1'b0;
    cycle();
    check("tp2_attack_pre", attack[7:4], 4'h0);
    do_tick();
    check("tp2_attack", attack[7:4], 4'hA);
    check("tp2_decay",  decay[7:4],  4'h5);

    // Gate retrigger within one sample period.
    do_write(8'h04, 8'h01);
    do_tick();
    check("tp3_gate_on", gate[0], 1'b1);
    do_write(8'h04, 8'h40);
    do_write(8'h04, 8'h41);
    do_tick();
    check("tp3_tick1_gate", gate[0], 1'b0);
    check("tp3_tick1_pulse", waveform_enable[2], 1'b1);
    do_tick();
    check("tp3_tick2_gate", gate[0], 1'b1);

    // PW_HI keeps only PULSEWIDTH_BITS-8 bits.
    do_write(8'h03, 8'hFF);
    rd_addr = 8'h03;
    cycle();
    check("tp4_pw_hi_read", rd_data, 8'h0F);
    do_tick();
    check("tp4_pw_hi_out", pulse_width[11:8], 4'hF);

    // Out-of-range voice: accepted, dropped, reads zero.
    do_write(8'h18, 8'h77);
    do_tick();
    rd_addr = 8'h18;
    cycle();
    check("tp5_oob_read", rd_data, 8'h00);

    // Reset between write and tick discards the pending write.
    do_write(8'h00, 8'h55);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    do_tick();
    check("tp6_freq_after_rst", tone_freq, '0);
    check("tp6_gate_after_rst", gate, '0);

    // Randomized traffic; the writer holds its request until accepted.
    for (int n = 0; n < 3000; n++) begin
      if (!wr_valid && $urandom_range(1, 0) == 1) begin
        logic [4:0] v;
        logic [2:0] r;
        v = ($urandom_range(9, 0) == 0) ? 5'($urandom_range(31, 0))
                                        : 5'($urandom_range(NV - 1, 0));
        r = ($urandom_range(2, 0) == 0) ? 3'd4 : 3'($urandom_range(7, 0));
        wr_valid = 1'b1;
        wr_addr  = {v, r};
        wr_data  = 8'($urandom);
      end
      sample_tick = ($urandom_range(7, 0) == 0);
      rst         = ($urandom_range(299, 0) == 0);
      rd_addr     = {5'($urandom_range(NV, 0)), 3'($urandom_range(7, 0))};
      cycle();
      if (last_accept) wr_valid = 1'b0;
    end
    rst = 1'b0;
    sample_tick = 1'b0;
    wr_valid = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
